// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run/step/breakpoint controller for a simple CPU pipeline. Turns a run
//   switch and a step button into a one-clk clock-enable pulse (cpu_ce).
//   In RUN, cpu_ce is paced by a programmable tick divider. A PC breakpoint
//   stops execution before the instruction at bp_addr advances.
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        asynchronous, active-low reset
//   run_sw       run request, asynchronous level (synchronized here)
//   step_btn     single-step request, asynchronous level (synchronized here)
//   div_sel      tick period minus one, in clk cycles (quasi-static)
//   bp_en        breakpoint enable
//   bp_addr      breakpoint PC
//   pc           current CPU PC, synchronous to clk
//   clr_count    synchronous clear of cycle_count
//   cpu_ce       one-clk clock-enable pulse to the pipeline
//   halted       high in HALT or BRK
//   state        encoded FSM state (HALT=0, RUN=1, STEP=2, BRK=3)
//   cycle_count  number of cpu_ce pulses issued (wraps)
module cpu_run_ctrl #(
    parameter int DIV_W = 8,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic             clr_count,
    output logic             cpu_ce,
    output logic             halted,
    output logic [1:0]       state,
    output logic [31:0]      cycle_count
);

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        BRK  = 2'b11
    } state_t;

    // Two-flop synchronizers plus one history flop for step edge detection
    logic run_meta_q, run_meta_d;
    logic run_s_q, run_s_d;
    logic step_meta_q, step_meta_d;
    logic step_s_q, step_s_d;
    logic step_prev_q, step_prev_d;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [31:0]      cycle_count_q, cycle_count_d;
    logic             halted_q, halted_d;

    logic step_edge;
    logic bp_hit;
    logic tick;
    logic ce;

    always_comb begin
        run_meta_d  = run_sw;
        run_s_d     = run_meta_q;
        step_meta_d = step_btn;
        step_s_d    = step_meta_q;
        step_prev_d = step_s_q;

        step_edge = step_s_q & ~step_prev_q;
        bp_hit    = bp_en & (pc == bp_addr);
        tick      = (state_q == RUN) & (div_cnt_q == div_sel);

        // A breakpoint hit masks the RUN pulse so the instruction at bp_addr
        // never advances; STEP is unconditional so a breakpoint can be
        // stepped off.
        ce = (state_q == STEP) | (tick & run_s_q & ~bp_hit);

        state_d = state_q;
        case (state_q)
            HALT: begin
                if (run_s_q) begin
                    state_d = RUN;
                end else if (step_edge) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (bp_hit) begin
                    state_d = BRK;
                end else if (!run_s_q) begin
                    state_d = HALT;
                end
            end
            STEP: begin
                state_d = HALT;
            end
            BRK: begin
                if (step_edge) begin
                    state_d = STEP;
                end else if (!run_s_q) begin
                    state_d = HALT;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase

        // Divider holds 0 outside RUN (including the entry cycle). Using >=
        // rather than == makes a div_sel reduction below the current count
        // wrap to 0 without producing a tick.
        div_cnt_d = '0;
        if ((state_q == RUN) && (state_d == RUN) && (div_cnt_q < div_sel)) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        // Clear wins over a simultaneous increment
        cycle_count_d = cycle_count_q;
        if (clr_count) begin
            cycle_count_d = '0;
        end else if (ce) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end

        halted_d = (state_d == HALT) | (state_d == BRK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_meta_q    <= 1'b0;
            run_s_q       <= 1'b0;
            step_meta_q   <= 1'b0;
            step_s_q      <= 1'b0;
            step_prev_q   <= 1'b0;
            state_q       <= HALT;
            div_cnt_q     <= '0;
            cycle_count_q <= '0;
            halted_q      <= 1'b1;
        end else begin
            run_meta_q    <= run_meta_d;
            run_s_q       <= run_s_d;
            step_meta_q   <= step_meta_d;
            step_s_q      <= step_s_d;
            step_prev_q   <= step_prev_d;
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            cycle_count_q <= cycle_count_d;
            halted_q      <= halted_d;
        end
    end

    assign cpu_ce      = ce;
    assign halted      = halted_q;
    assign state       = state_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter DIV_W, default 8, width of the tick-divide value.
REQ-002 Parameter PC_W, default 32, width of PC and breakpoint address.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 run_sw  input  1  run request, asynchronous level from a switch.
REQ-006 step_btn  input  1  single-step request, asynchronous level from a button.
REQ-007 div_sel  input  DIV_W  tick period minus one, in clk cycles; quasi-static.
REQ-008 bp_en  input  1  breakpoint enable.
REQ-009 bp_addr  input  PC_W  breakpoint PC.
REQ-010 pc  input  PC_W  current CPU PC, synchronous to clk.
REQ-011 clr_count  input  1  synchronous clear of cycle_count.
REQ-012 cpu_ce  output  1  one-clk clock-enable pulse to the pipeline.
REQ-013 halted  output  1  high in HALT or BRK.
REQ-014 state  output  2  encoded FSM state.
REQ-015 cycle_count  output  32  number of cpu_ce pulses issued.

Function
REQ-016 run_sw and step_btn SHALL each pass through a 2-flop synchronizer (run_s, step_s) before any use.
REQ-017 step_edge SHALL be one clk high when step_s is 1 and was 0 the previous cycle.
REQ-018 FSM states: HALT=2'b00, RUN=2'b01, STEP=2'b10, BRK=2'b11; state output SHALL equal the current state register.
REQ-019 HALT: run_s=1 -> RUN; else step_edge -> STEP; else stay. run_s has priority.
REQ-020 RUN: bp_hit -> BRK; else run_s=0 -> HALT; else stay. bp_hit = bp_en & (pc == bp_addr).
REQ-021 STEP: unconditionally -> HALT after one cycle.
REQ-022 BRK: step_edge -> STEP; else run_s=0 -> HALT; else stay (run_s must drop to leave BRK for HALT).
REQ-023 Divider counter SHALL be 0 whenever state != RUN, and in RUN count 0..div_sel, wrapping to 0; tick = RUN & (count == div_sel).
REQ-024 div_sel=0 SHALL produce tick every clk in RUN; div_sel=N gives period N+1.
REQ-025 cpu_ce SHALL be (state==STEP) | (tick & run_s & ~bp_hit), decoded from registers and synchronized signals only.
REQ-026 Exactly one cpu_ce pulse per STEP visit; STEP ignores bp_hit, allowing stepping off a breakpoint.
REQ-027 A breakpoint halts before the instruction at bp_addr advances: no cpu_ce in a cycle with bp_hit in RUN.
REQ-028 First cpu_ce after entering RUN SHALL occur div_sel+1 cycles after entry.
REQ-029 halted SHALL be 1 in HALT and BRK, 0 in RUN and STEP.
REQ-030 cycle_count SHALL increment by 1 on each cycle with cpu_ce=1, wrapping 0xFFFF_FFFF -> 0.
REQ-031 clr_count=1 SHALL load 0, taking priority over a simultaneous increment.
REQ-032 Changing div_sel in RUN below the current count SHALL wrap the counter to 0 at the next clk without a tick.

Reset
REQ-033 reset=0 SHALL asynchronously force state=HALT, divider=0, synchronizers=0, step history=0, cycle_count=0; hence cpu_ce=0, halted=1.
REQ-034 Reset asserted mid-RUN or mid-STEP SHALL suppress any pending cpu_ce; after release the block stays in HALT until a fresh run_s=1 or step edge.
REQ-035 Release of reset with run_sw already high SHALL enter RUN 3 clk later (2 synchronizer + 1 FSM).

Verification
REQ-036 reset release, run_sw=1, div_sel=3, bp_en=0 -> RUN after 3 clk; cpu_ce every 4th clk; cycle_count=5 after 20 clk in RUN.
REQ-037 HALT, run_sw=0, step_btn held high 50 clk -> exactly one cpu_ce, state STEP then HALT, cycle_count +1.
REQ-038 RUN, div_sel=0, bp_en=1, bp_addr=0x10, pc driven 0x0C then 0x10 -> no cpu_ce in the 0x10 cycle, state=BRK, halted=1; step press -> one cpu_ce, then HALT.
REQ-039 RUN with div_sel=0 and cycle_count preset near 0xFFFF_FFFE via pulses -> wraps to 0; clr_count same cycle as cpu_ce -> 0.
REQ-040 reset=0 asserted asynchronously between clk edges during RUN -> cpu_ce, state, cycle_count go to 0 immediately; no pulse on next edge.
REQ-041 run_sw toggled 1->0 in RUN coincident with tick -> at most one further cpu_ce before HALT, none after.
